btrain_frame_rx: RTL

Receive-side BTrain frame decoder for the SPEC reference design. It consumes the word stream delivered by the WR RX streamer and parses Bframes (B and Bdot) and Iframes (current). It publishes the decoded values with one-cycle valid strobes and keeps frame, error, loss and sequence-gap statistics. It is the counterpart of the frame builder that feeds the TX streamer on the sending SPEC.

---
 rtl/btrain_frame_rx_if.sv | 31 +++
 rtl/btrain_frame_rx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btrain_frame_rx_if.sv
// ---------------------------------------------------------------------------
// btrain_frame_rx_if
// Word-stream link between the WR RX streamer and the BTrain frame decoder.
//   rx_data_i   streamer data word
//   rx_valid_i  data word valid this cycle
//   rx_first_i  word is the first of a frame (qualified by rx_valid_i)
//   rx_last_i   word is the last of a frame (qualified by rx_valid_i)
//   rx_lost_i   streamer reports lost frame(s), single-cycle pulse
//   rx_dreq_o   data request back to the streamer
// master: streamer side, slave: decoder side.
// ---------------------------------------------------------------------------
interface btrain_frame_rx_if #(
   parameter int g_data_width = 32
);
   logic [g_data_width-1:0] rx_data_i;
   logic                    rx_valid_i;
   logic                    rx_first_i;
   logic                    rx_last_i;
   logic                    rx_lost_i;
   logic                    rx_dreq_o;

   modport master (
      output rx_data_i, rx_valid_i, rx_first_i, rx_last_i, rx_lost_i,
      input  rx_dreq_o
   );

   modport slave (
      input  rx_data_i, rx_valid_i, rx_first_i, rx_last_i, rx_lost_i,
      output rx_dreq_o
   );
endinterface

// File: rtl/btrain_frame_rx.sv
// ---------------------------------------------------------------------------
// btrain_frame_rx
// Receive-side BTrain frame decoder. Parses Bframes (header, B, Bdot) and
// Iframes (header, I) from the RX streamer word stream, publishes decoded
// values with one-cycle strobes and keeps frame/error/loss/gap statistics.
// Ports:
//   clk_sys_i, rst_n_i   clock, asynchronous active-low reset
//   enable_i             decoder enable (words ignored when low)
//   rx                   streamer link (slave modport)
//   b_value_o, bdot_value_o, b_valid_p1_o   last good Bframe + strobe
//   i_value_o, i_valid_p1_o                 last good Iframe + strobe
//   flags_o              header flags of the last good frame
//   seq_gap_p1_o         strobe on a sequence discontinuity
//   cnt_b_o, cnt_i_o     good frame counters (wrapping)
//   cnt_err_o, cnt_lost_o, cnt_gap_o   saturating statistics
//   cnt_clr_i            synchronous clear of counters and sequence history
// ---------------------------------------------------------------------------
module btrain_frame_rx #(
   parameter int g_data_width    = 32,
   parameter int g_err_cnt_width = 16
) (
   input  logic                       clk_sys_i,
   input  logic                       rst_n_i,
   input  logic                       enable_i,
   btrain_frame_rx_if.slave           rx,
   output logic [31:0]                b_value_o,
   output logic [31:0]                bdot_value_o,
   output logic                       b_valid_p1_o,
   output logic [31:0]                i_value_o,
   output logic                       i_valid_p1_o,
   output logic [7:0]                 flags_o,
   output logic                       seq_gap_p1_o,
   output logic [31:0]                cnt_b_o,
   output logic [31:0]                cnt_i_o,
   output logic [g_err_cnt_width-1:0] cnt_err_o,
   output logic [g_err_cnt_width-1:0] cnt_lost_o,
   output logic [g_err_cnt_width-1:0] cnt_gap_o,
   input  logic                       cnt_clr_i
);

   localparam logic [7:0] TYPE_B = 8'h42;
   localparam logic [7:0] TYPE_I = 8'h49;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_B_PAY = 2'd1,
      ST_I_PAY = 2'd2,
      ST_DROP  = 2'd3
   } state_t;

   // Saturating add; an abort plus a bad header can cost two errors at once.
   function automatic logic [g_err_cnt_width-1:0] sat_add(
      input logic [g_err_cnt_width-1:0] a,
      input logic [1:0]                 inc
   );
      logic [g_err_cnt_width:0] s;
      s = {1'b0, a} + {{(g_err_cnt_width-1){1'b0}}, inc};
      return s[g_err_cnt_width] ? {g_err_cnt_width{1'b1}} : s[g_err_cnt_width-1:0];
   endfunction

   state_t                     state_r, state_n_s;
   logic                       pay_idx_r, pay_idx_n_s;   // 0: first payload word pending
   logic [g_data_width-1:0]    word_s;
   logic [23:0]                hdr_sh_r;                 // flags + sequence of the frame in flight
   logic [31:0]                b_sh_r;
   logic                       hdr_ld_s, b_ld_s, commit_b_s, commit_i_s;
   logic                       abort_s, fmt_err_s, commit_s, gap_s;
   logic [1:0]                 err_inc_s;
   logic [15:0]                seq_s, seq_next_s, seq_prev_r;
   logic                       seq_valid_r;

   logic                       dreq_r, b_valid_r, i_valid_r, gap_r;
   logic [31:0]                b_value_r, bdot_value_r, i_value_r, cnt_b_r, cnt_i_r;
   logic [7:0]                 flags_r;
   logic [g_err_cnt_width-1:0] cnt_err_r, cnt_lost_r, cnt_gap_r;

   assign word_s     = rx.rx_data_i;
   assign err_inc_s  = {1'b0, abort_s} + {1'b0, fmt_err_s};
   assign commit_s   = commit_b_s | commit_i_s;
   assign seq_s      = hdr_sh_r[15:0];
   assign seq_next_s = seq_prev_r + 16'd1;
   assign gap_s      = seq_valid_r && (seq_s != seq_next_s);

   // Next-state and datapath control of the frame parser.
   always_comb begin
      state_n_s   = state_r;
      pay_idx_n_s = pay_idx_r;
      hdr_ld_s    = 1'b0;
      b_ld_s      = 1'b0;
      commit_b_s  = 1'b0;
      commit_i_s  = 1'b0;
      abort_s     = 1'b0;
      fmt_err_s   = 1'b0;
      if (!enable_i) begin
         state_n_s = ST_IDLE;
      end else if (rx.rx_lost_i) begin
         // loss wins over any word presented in the same cycle
         state_n_s = ST_IDLE;
      end else if (rx.rx_valid_i && rx.rx_first_i) begin
         // a first word always restarts parsing, even mid-frame or in DROP
         abort_s     = (state_r != ST_IDLE);
         pay_idx_n_s = 1'b0;
         case (word_s[31:24])
            TYPE_B, TYPE_I: begin
               if (rx.rx_last_i) begin
                  fmt_err_s = 1'b1;
                  state_n_s = ST_IDLE;
               end else begin
                  hdr_ld_s  = 1'b1;
                  state_n_s = (word_s[31:24] == TYPE_B) ? ST_B_PAY : ST_I_PAY;
               end
            end
            default: begin
               fmt_err_s = 1'b1;
               state_n_s = rx.rx_last_i ? ST_IDLE : ST_DROP;
            end
         endcase
      end else if (rx.rx_valid_i) begin
         case (state_r)
            ST_B_PAY: begin
               if (!pay_idx_r) begin
                  if (rx.rx_last_i) begin
                     fmt_err_s = 1'b1;
                     state_n_s = ST_IDLE;
                  end else begin
                     b_ld_s      = 1'b1;
                     pay_idx_n_s = 1'b1;
                  end
               end else if (rx.rx_last_i) begin
                  commit_b_s = 1'b1;
                  state_n_s  = ST_IDLE;
               end else begin
                  fmt_err_s = 1'b1;
                  state_n_s = ST_DROP;
               end
            end
            ST_I_PAY: begin
               if (rx.rx_last_i) begin
                  commit_i_s = 1'b1;
                  state_n_s  = ST_IDLE;
               end else begin
                  fmt_err_s = 1'b1;
                  state_n_s = ST_DROP;
               end
            end
            ST_DROP: begin
               if (rx.rx_last_i) begin
                  state_n_s = ST_IDLE;
               end else begin
                  state_n_s = ST_DROP;
               end
            end
            default: begin
               // stray words without first are ignored in IDLE
               state_n_s = ST_IDLE;
            end
         endcase
      end else begin
         state_n_s = state_r;
      end
   end

   // Parser state, shadow capture and published values.
   always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_r      <= ST_IDLE;
         pay_idx_r    <= 1'b0;
         hdr_sh_r     <= 24'd0;
         b_sh_r       <= 32'd0;
         b_value_r    <= 32'd0;
         bdot_value_r <= 32'd0;
         i_value_r    <= 32'd0;
         flags_r      <= 8'd0;
         b_valid_r    <= 1'b0;
         i_valid_r    <= 1'b0;
         dreq_r       <= 1'b0;
      end else begin
         state_r   <= state_n_s;
         pay_idx_r <= pay_idx_n_s;
         dreq_r    <= enable_i;
         b_valid_r <= commit_b_s;
         i_valid_r <= commit_i_s;
         if (hdr_ld_s) hdr_sh_r <= word_s[23:0];
         if (b_ld_s)   b_sh_r   <= word_s[31:0];
         if (commit_b_s) begin
            b_value_r    <= b_sh_r;
            bdot_value_r <= word_s[31:0];
            flags_r      <= hdr_sh_r[23:16];
         end
         if (commit_i_s) begin
            i_value_r <= word_s[31:0];
            flags_r   <= hdr_sh_r[23:16];
         end
      end
   end

   // Statistics counters and sequence history; a clear beats any increment.
   always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_b_r     <= 32'd0;
         cnt_i_r     <= 32'd0;
         cnt_err_r   <= {g_err_cnt_width{1'b0}};
         cnt_lost_r  <= {g_err_cnt_width{1'b0}};
         cnt_gap_r   <= {g_err_cnt_width{1'b0}};
         seq_prev_r  <= 16'd0;
         seq_valid_r <= 1'b0;
         gap_r       <= 1'b0;
      end else if (cnt_clr_i) begin
         cnt_b_r     <= 32'd0;
         cnt_i_r     <= 32'd0;
         cnt_err_r   <= {g_err_cnt_width{1'b0}};
         cnt_lost_r  <= {g_err_cnt_width{1'b0}};
         cnt_gap_r   <= {g_err_cnt_width{1'b0}};
         seq_valid_r <= 1'b0;
         gap_r       <= 1'b0;
      end else begin
         gap_r      <= 1'b0;
         cnt_err_r  <= sat_add(cnt_err_r, err_inc_s);
         cnt_lost_r <= sat_add(cnt_lost_r, {1'b0, rx.rx_lost_i});
         if (commit_b_s) cnt_b_r <= cnt_b_r + 32'd1;
         if (commit_i_s) cnt_i_r <= cnt_i_r + 32'd1;
         if (commit_s) begin
            seq_prev_r  <= seq_s;
            seq_valid_r <= 1'b1;
            if (gap_s) begin
               gap_r     <= 1'b1;
               cnt_gap_r <= sat_add(cnt_gap_r, 2'd1);
            end
         end
      end
   end

   assign rx.rx_dreq_o  = dreq_r;
   assign b_value_o     = b_value_r;
   assign bdot_value_o  = bdot_value_r;
   assign b_valid_p1_o  = b_valid_r;
   assign i_value_o     = i_value_r;
   assign i_valid_p1_o  = i_valid_r;
   assign flags_o       = flags_r;
   assign seq_gap_p1_o  = gap_r;
   assign cnt_b_o       = cnt_b_r;
   assign cnt_i_o       = cnt_i_r;
   assign cnt_err_o     = cnt_err_r;
   assign cnt_lost_o    = cnt_lost_r;
   assign cnt_gap_o     = cnt_gap_r;

endmodule
